// File: rtl/core_pkg.sv
// Shared MIPS core definitions: write-back select codes, MEM FSM states, widths.
package core_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned DADDR_W = 30;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic              reg_write;
    logic [REG_AW-1:0] write_reg;
    logic [XLEN-1:0]   wb_data;
  } memwb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bundle between the MEM stage and the D-cache.
interface mem_wb_stage_if;
  import core_pkg::*;

  logic               DCACHE_ren;
  logic               DCACHE_wen;
  logic [DADDR_W-1:0] DCACHE_addr;
  logic [XLEN-1:0]    DCACHE_wdata;
  logic [XLEN-1:0]    DCACHE_rdata;
  logic               DCACHE_stall;

  modport master (
    output DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
    input  DCACHE_rdata, DCACHE_stall
  );

  modport slave (
    input  DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
    output DCACHE_rdata, DCACHE_stall
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory stage: D-cache request FSM, write-back select, MEM/WB register,
// global memory stall and saturating perf counters.
module mem_wb_stage
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CacheRead_i,
  input  logic              CacheWrite_i,
  input  logic [1:0]        CachetoReg_i,
  input  logic              RegWrite_i,
  input  logic [XLEN-1:0]   ALU_result_i,
  input  logic [XLEN-1:0]   Write_data_i,
  input  logic [XLEN-1:0]   incremented_PC_i,
  input  logic [REG_AW-1:0] WriteReg_i,
  input  logic              ext_stall_i,
  mem_wb_stage_if.master    dcache,
  output logic              mem_stall_o,
  output logic              RegWrite_o,
  output logic [REG_AW-1:0] WriteReg_o,
  output logic [XLEN-1:0]   WB_data_o,
  output logic [XLEN-1:0]   fwd_data_o,
  output logic [CNT_W-1:0]  perf_access_o,
  output logic [CNT_W-1:0]  perf_stall_o
);

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] rbuf_q, rbuf_d;
  memwb_t          memwb_q, memwb_d;

  logic            access_c;
  logic            acc_done_c;
  logic            freeze_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] wb_data_c;

  assign access_c = CacheRead_i | CacheWrite_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Request FSM; DONE parks a finished access so it is not reissued while frozen.
  always_comb begin
    state_d           = state_q;
    rbuf_d            = rbuf_q;
    dcache.DCACHE_ren = 1'b0;
    dcache.DCACHE_wen = 1'b0;
    mem_stall_o       = 1'b0;
    acc_done_c        = 1'b0;

    if (rst_n && (state_q != MEM_DONE)) begin
      dcache.DCACHE_ren = CacheRead_i;
      dcache.DCACHE_wen = CacheWrite_i & ~CacheRead_i;
      mem_stall_o       = access_c & dcache.DCACHE_stall;
      acc_done_c        = access_c & ~dcache.DCACHE_stall;
    end

    case (state_q)
      MEM_IDLE: begin
        if (access_c) begin
          if (dcache.DCACHE_stall) begin
            state_d = MEM_WAIT;
          end else if (ext_stall_i) begin
            state_d = MEM_DONE;
            rbuf_d  = dcache.DCACHE_rdata;
          end
        end
      end
      MEM_WAIT: begin
        if (!access_c) begin
          state_d = MEM_IDLE;
        end else if (!dcache.DCACHE_stall) begin
          if (ext_stall_i) begin
            state_d = MEM_DONE;
            rbuf_d  = dcache.DCACHE_rdata;
          end else begin
            state_d = MEM_IDLE;
          end
        end
      end
      MEM_DONE: begin
        if (!ext_stall_i) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign dcache.DCACHE_addr  = ALU_result_i[XLEN-1:2];
  assign dcache.DCACHE_wdata = Write_data_i;

  // Write-back and forwarding value selection.
  always_comb begin
    load_data_c = (state_q == MEM_DONE) ? rbuf_q : dcache.DCACHE_rdata;
    wb_data_c   = ALU_result_i;
    fwd_data_o  = ALU_result_i;
    case (wb_sel_e'(CachetoReg_i))
      WB_MEM: wb_data_c = load_data_c;
      WB_PC: begin
        wb_data_c  = incremented_PC_i;
        fwd_data_o = incremented_PC_i;
      end
      default: ;
    endcase
  end

  assign freeze_c = mem_stall_o | ext_stall_i;

  always_comb begin
    memwb_d = memwb_q;
    if (!freeze_c) begin
      memwb_d.reg_write = RegWrite_i;
      memwb_d.write_reg = WriteReg_i;
      memwb_d.wb_data   = wb_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) memwb_q <= '0;
    else        memwb_q <= memwb_d;
  end

  assign RegWrite_o = memwb_q.reg_write;
  assign WriteReg_o = memwb_q.write_reg;
  assign WB_data_o  = memwb_q.wb_data;

  sat_counter u_access_cnt (
    .clk     (clk),
    .clr_i   (~rst_n),
    .en_i    (acc_done_c),
    .count_o (perf_access_o)
  );

  sat_counter u_stall_cnt (
    .clk     (clk),
    .clr_i   (~rst_n),
    .en_i    (mem_stall_o),
    .count_o (perf_stall_o)
  );

endmodule
